// File: rtl/mio_bus.sv
// Memory/IO bus bridge: turns CPU read/write requests into wait-stated RAM
// accesses or single-cycle accesses to a small LED/switch/counter register map.
module mio_bus #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [3:0]  IO_TAG      = 4'hF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        mio_ready,
    output logic        ram_en,
    output logic        ram_we,
    output logic [9:0]  ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    input  logic [15:0] sw_in,
    output logic [15:0] led_out,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

    state_t      state, state_next;
    logic [3:0]  cap_tag;
    logic [9:0]  cap_word;
    logic [31:0] cap_wdata;
    logic        cap_wr;
    logic [3:0]  wait_cnt;
    logic [31:0] cyc_cnt;
    logic [31:0] io_rdata;
    logic        is_io;
    logic        last_access;
    logic        unused_addr_bits;

    // Only the space tag and the word address matter once a request is captured.
    assign unused_addr_bits = ^{addr[27:12], addr[1:0]};

    assign is_io       = (cap_tag == IO_TAG);
    assign last_access = (state == S_ACCESS) && (is_io || (wait_cnt == WAIT_LAST));
    assign ram_addr    = cap_word;
    assign ram_wdata   = cap_wdata;
    assign state_dbg   = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (mem_rd || mem_wr) state_next = S_ACCESS;
            S_ACCESS: if (last_access)      state_next = S_DONE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        ram_en    = (state == S_ACCESS) && !is_io;
        ram_we    = ram_en && cap_wr && (wait_cnt == 4'd0);
        mio_ready = (state == S_DONE);
    end

    always_comb begin
        io_rdata = 32'd0;
        case (cap_word[1:0])
            2'd0:    io_rdata = {16'd0, led_out};
            2'd1:    io_rdata = {16'd0, sw_in};
            2'd2:    io_rdata = cyc_cnt;
            default: io_rdata = 32'd0;
        endcase
    end

    // Capture on the sample edge so later addr/wdata changes cannot disturb the access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_tag   <= 4'd0;
            cap_word  <= 10'd0;
            cap_wdata <= 32'd0;
            cap_wr    <= 1'b0;
            wait_cnt  <= 4'd0;
        end else if (state == S_IDLE) begin
            wait_cnt <= 4'd0;
            if (mem_rd || mem_wr) begin
                cap_tag   <= addr[31:28];
                cap_word  <= addr[11:2];
                cap_wdata <= wdata;
                cap_wr    <= mem_wr;
            end
        end else if (state == S_ACCESS) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata   <= 32'd0;
            led_out <= 16'd0;
        end else if (last_access) begin
            if (!cap_wr)
                rdata <= is_io ? io_rdata : ram_rdata;
            else if (is_io && (cap_word[1:0] == 2'd0))
                led_out <= cap_wdata[15:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cyc_cnt <= 32'd0;
        else       cyc_cnt <= cyc_cnt + 32'd1;
    end

endmodule

// File: tb/tb_mio_bus.sv
// Directed bench for mio_bus: RAM and IO reads/writes, latency, capture,
// mid-transaction reset and cycle-counter behaviour.
module tb_mio_bus;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_rd, mem_wr;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        mio_ready, ram_en, ram_we;
    logic [9:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [15:0] sw_in;
    logic [15:0] led_out;
    logic [1:0]  state_dbg;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] r;
    int          lat, en_n, we_n, rdy_n;
    logic [9:0]  wa;

    logic [31:0] ram_mem [0:1023];

    mio_bus #(.WAIT_CYCLES(2), .IO_TAG(4'hF)) dut (
        .clk(clk), .reset(reset), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .addr(addr), .wdata(wdata), .rdata(rdata), .mio_ready(mio_ready),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .sw_in(sw_in),
        .led_out(led_out), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Synchronous RAM with one-cycle read latency; reset restores the preload.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 1024; i++) ram_mem[i] <= 32'd0;
            ram_mem[4] <= 32'hDEADBEEF;
            ram_rdata  <= 32'd0;
        end else if (ram_en) begin
            if (ram_we) ram_mem[ram_addr] <= ram_wdata;
            ram_rdata <= ram_mem[ram_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic txn(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd_o, output int lat_o, output int en_o,
                       output int we_o, output logic [9:0] wa_o);
        mem_rd = rd; mem_wr = wr; addr = a; wdata = d;
        lat_o = 0; en_o = 0; we_o = 0; wa_o = 10'd0; rd_o = 32'd0;
        @(posedge clk); #1;
        addr = ~a; wdata = ~d;
        for (int cnt = 0; cnt < 40 && lat_o == 0; cnt++) begin
            if (ram_en) en_o++;
            if (ram_we) begin we_o++; wa_o = ram_addr; end
            if (mio_ready) begin
                lat_o = cnt + 1;
                rd_o  = rdata;
            end else begin
                @(posedge clk); #1;
            end
        end
        mem_rd = 1'b0; mem_wr = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0;
        addr = 32'd0; wdata = 32'd0; sw_in = 16'h00FF;
        repeat (2) @(negedge clk);
        check("rst_rdata", rdata, 32'd0);
        check("rst_ready", {31'd0, mio_ready}, 32'd0);
        check("rst_ram_en", {31'd0, ram_en}, 32'd0);
        check("rst_ram_we", {31'd0, ram_we}, 32'd0);
        check("rst_led", {16'd0, led_out}, 32'd0);
        check("rst_state", {30'd0, state_dbg}, 32'd0);
        check("rst_ram_addr", {22'd0, ram_addr}, 32'd0);
        check("rst_ram_wdata", ram_wdata, 32'd0);
        reset = 1'b0;

        // Counter: released at a negedge, 5 edges pass, sampled on the 6th.
        repeat (5) @(posedge clk);
        @(negedge clk);
        txn(1'b1, 1'b0, 32'hF0000008, 32'd0, r, lat, en_n, we_n, wa);
        check("cnt_after_reset", r, 32'd6);
        check("cnt_lat", lat, 2);

        txn(1'b1, 1'b0, 32'h00000010, 32'd0, r, lat, en_n, we_n, wa);
        check("ram_rd_data", r, 32'hDEADBEEF);
        check("ram_rd_lat", lat, 4);
        check("ram_rd_en_cycles", en_n, 3);
        check("ram_rd_we_cycles", we_n, 0);

        txn(1'b0, 1'b1, 32'h00000020, 32'h12345678, r, lat, en_n, we_n, wa);
        check("ram_wr_we_cycles", we_n, 1);
        check("ram_wr_we_addr", {22'd0, wa}, 32'd8);
        check("ram_wr_en_cycles", en_n, 3);
        check("ram_wr_lat", lat, 4);
        txn(1'b1, 1'b0, 32'h00000020, 32'd0, r, lat, en_n, we_n, wa);
        check("ram_readback", r, 32'h12345678);

        txn(1'b0, 1'b1, 32'hF0000000, 32'h0000A5A5, r, lat, en_n, we_n, wa);
        check("io_wr_led", {16'd0, led_out}, 32'h0000A5A5);
        check("io_wr_lat", lat, 2);
        check("io_wr_ram_en", en_n, 0);
        txn(1'b1, 1'b0, 32'hF0000000, 32'd0, r, lat, en_n, we_n, wa);
        check("io_rd_led", r, 32'h0000A5A5);
        check("io_rd_led_lat", lat, 2);
        txn(1'b1, 1'b0, 32'hF0000004, 32'd0, r, lat, en_n, we_n, wa);
        check("io_rd_sw", r, 32'h000000FF);
        check("io_rd_sw_lat", lat, 2);
        txn(1'b0, 1'b1, 32'hF0000004, 32'h00001234, r, lat, en_n, we_n, wa);
        check("io_wr_ro_dropped", {16'd0, led_out}, 32'h0000A5A5);
        txn(1'b0, 1'b1, 32'hF000000C, 32'h00005555, r, lat, en_n, we_n, wa);
        check("io_wr_unmapped_dropped", {16'd0, led_out}, 32'h0000A5A5);
        txn(1'b1, 1'b0, 32'hF000000C, 32'd0, r, lat, en_n, we_n, wa);
        check("io_rd_unmapped", r, 32'd0);

        txn(1'b1, 1'b1, 32'h00000000, 32'h00000001, r, lat, en_n, we_n, wa);
        check("both_is_write_we", we_n, 1);
        check("both_is_write_addr", {22'd0, wa}, 32'd0);
        txn(1'b1, 1'b0, 32'h00000000, 32'd0, r, lat, en_n, we_n, wa);
        check("both_readback", r, 32'h00000001);

        // Reset during the 2nd ACCESS cycle of a RAM read.
        mem_rd = 1'b1; addr = 32'h00000010;
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("midrst_ready", {31'd0, mio_ready}, 32'd0);
        check("midrst_rdata", rdata, 32'd0);
        check("midrst_led", {16'd0, led_out}, 32'd0);
        check("midrst_ram_en", {31'd0, ram_en}, 32'd0);
        check("midrst_state", {30'd0, state_dbg}, 32'd0);
        mem_rd = 1'b0;
        rdy_n = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (mio_ready) rdy_n++;
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (mio_ready) rdy_n++;
        end
        check("midrst_no_ready", rdy_n, 0);
        @(negedge clk);
        txn(1'b1, 1'b0, 32'h00000010, 32'd0, r, lat, en_n, we_n, wa);
        check("postrst_rd_data", r, 32'hDEADBEEF);
        check("postrst_rd_lat", lat, 4);

        // Counter wrap.
        force dut.cyc_cnt = 32'hFFFFFFFF;
        #1 release dut.cyc_cnt;
        @(posedge clk); #1;
        check("cnt_wrap_direct", dut.cyc_cnt, 32'd0);
        @(negedge clk);
        force dut.cyc_cnt = 32'hFFFFFFFF;
        #1 release dut.cyc_cnt;
        txn(1'b1, 1'b0, 32'hF0000008, 32'd0, r, lat, en_n, we_n, wa);
        check("cnt_wrap_read", r, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mio_bus.md
MIO_BUS -- requirements
Module: mio_bus

Interface
REQ-001 Parameter WAIT_CYCLES, default 2: extra RAM wait states per RAM access; legal 0..15.
REQ-002 Parameter IO_TAG, default 4'hF: value of addr[31:28] that selects IO space.
REQ-003 Clocking: reset is asynchronous, active-high; clock is clk.
REQ-004 clk  input  1  system clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 mem_rd  input  1  read request from the CPU controller; held high until mio_ready is seen.
REQ-007 mem_wr  input  1  write request from the CPU controller; held high until mio_ready is seen.
REQ-008 addr  input  32  byte address; addr[1:0] ignored.
REQ-009 wdata  input  32  write data.
REQ-010 rdata  output  32  read data; registered; holds its value until the next completed read.
REQ-011 mio_ready  output  1  one-cycle completion pulse.
REQ-012 ram_en  output  1  RAM enable.
REQ-013 ram_we  output  1  RAM write strobe.
REQ-014 ram_addr  output  10  RAM word address (addr[11:2] as captured).
REQ-015 ram_wdata  output  32  RAM write data (as captured).
REQ-016 ram_rdata  input  32  synchronous RAM read data; valid the cycle after ram_en.
REQ-017 sw_in  input  16  board switches.
REQ-018 led_out  output  16  LED register.

Function
REQ-019 FSM states: IDLE, ACCESS, DONE.
REQ-020 IDLE: when mem_rd or mem_wr is sampled high, the block SHALL capture addr, wdata and the request type, then enter ACCESS.
REQ-021 Simultaneous mem_rd and mem_wr: treated as a write.
REQ-022 Space select: the block SHALL decode captured addr[31:28]==IO_TAG as IO; all other values are RAM.
REQ-023 RAM in ACCESS: ram_en=1 for WAIT_CYCLES+1 cycles; ram_we=1 in the first ACCESS cycle of a write only. On the last ACCESS cycle of a read, the block SHALL load rdata from ram_rdata.
REQ-024 IO in ACCESS: exactly one cycle; ram_en=0. Register map by addr[3:2]:
- 0: LED, R/W; writes load wdata[15:0]; reads return zero-extended led_out.
- 1: switches, R only; reads return zero-extended sw_in.
- 2: cycle counter, R only.
- 3: unmapped; reads return 0.
Writes to read-only or unmapped offsets SHALL be dropped.
REQ-025 Exiting ACCESS goes to DONE; mio_ready=1 only while in DONE; DONE always returns to IDLE the next cycle.
REQ-026 Requests are sampled in IDLE only. A request that is still high on return to IDLE starts a new transaction (back-to-back allowed).
REQ-027 Latency from the request-sample edge to mio_ready high: RAM = WAIT_CYCLES+2 cycles; IO = 2 cycles.
REQ-028 Cycle counter: 32-bit, +1 every clk, wraps 32'hFFFFFFFF->0, independent of the FSM.
REQ-029 addr/wdata changes after capture SHALL NOT affect an in-flight transaction.
REQ-030 ram_addr and ram_wdata SHALL be driven from the captured values.

Reset
REQ-031 On reset, including mid-transaction: state=IDLE; rdata=0; mio_ready=0; ram_en=0; ram_we=0; led_out=0; counter=0; capture registers=0. The in-flight transaction SHALL be abandoned without completing.
REQ-032 Release: the first request is sampled on the first rising edge with reset low.

Verification
REQ-033 WAIT_CYCLES=2; RAM read at 0x00000010 (RAM word 4 = 0xDEADBEEF) -> ram_en high 3 cycles; mio_ready pulses 4 cycles after sample; rdata=0xDEADBEEF.
REQ-034 RAM write 0x12345678 to 0x00000020, then read the same address -> ram_we high exactly 1 cycle with ram_addr=8; readback 0x12345678.
REQ-035 IO write 0x0000A5A5 to 0xF0000000, then read 0xF0000000 and 0xF0000004 with sw_in=0x00FF -> led_out=0xA5A5; reads return 0x0000A5A5 and 0x000000FF; each mio_ready 2 cycles after sample.
REQ-036 mem_rd and mem_wr both high at 0x00000000 with wdata=0x1 -> write performed (ram_we pulse); a subsequent read returns 0x1.
REQ-037 Reset asserted in the 2nd ACCESS cycle of a RAM read -> no mio_ready pulse; rdata=0, led_out=0, ram_en=0 immediately; after release, a fresh read completes normally.
REQ-038 Counter read at 0xF0000008 N cycles after reset -> value equals elapsed cycles; force the counter to 32'hFFFFFFFF -> it reads 0 one cycle later.
